// File: rtl/picomips_pkg.sv
// Shared sizing constants for the picoMIPS fetch path.
package picomips_pkg;

    localparam int unsigned PSIZE       = 6;
    localparam int unsigned ISIZE       = 20;
    localparam int unsigned FETCH_DEPTH = 2;
    localparam int unsigned CNT_W       = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned OCC_W       = CNT_W + 1;

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch bus: PC request, synchronous ROM port and decoder handshake.
interface instr_fetch_if
    import picomips_pkg::*;
#(
    parameter int unsigned Psize = PSIZE,
    parameter int unsigned Isize = ISIZE
);

    logic             req_valid;
    logic [Psize-1:0] req_addr;
    logic             req_ready;
    logic             flush;
    logic [Psize-1:0] rom_addr;
    logic [Isize-1:0] rom_data;
    logic             instr_valid;
    logic [Isize-1:0] instr;
    logic [Psize-1:0] instr_addr;
    logic             instr_ready;

    // Fetch unit side
    modport master (
        input  req_valid, req_addr, flush, rom_data, instr_ready,
        output req_ready, rom_addr, instr_valid, instr, instr_addr
    );

    // PC / ROM / decoder side
    modport slave (
        output req_valid, req_addr, flush, rom_data, instr_ready,
        input  req_ready, rom_addr, instr_valid, instr, instr_addr
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding fetched word and its address.
module fetch_fifo
    import picomips_pkg::*;
#(
    parameter int unsigned Psize = PSIZE,
    parameter int unsigned Isize = ISIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [Isize-1:0] push_data_i,
    input  logic [Psize-1:0] push_addr_i,
    output logic [CNT_W-1:0] count_o,
    output logic [Isize-1:0] head_data_o,
    output logic [Psize-1:0] head_addr_o
);

    logic [Isize-1:0] data_q [FETCH_DEPTH];
    logic [Psize-1:0] addr_q [FETCH_DEPTH];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next state; clear wins over push/pop
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = ~wptr_q;
            if (pop_i)  rptr_d = ~rptr_q;
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero while empty after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(FETCH_DEPTH); i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else if (push_i && !clear_i) begin
            data_q[wptr_q] <= push_data_i;
            addr_q[wptr_q] <= push_addr_i;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = data_q[rptr_q];
    assign head_addr_o = addr_q[rptr_q];

    // The request throttle must keep a landing word from ever meeting a full buffer
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push_i && !clear_i && (count_q == CNT_W'(FETCH_DEPTH))));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: request handshake, one-deep ROM in-flight tracking, 2-entry buffer.
module instr_fetch
    import picomips_pkg::*;
#(
    parameter int unsigned Psize = PSIZE,
    parameter int unsigned Isize = ISIZE
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    logic             inflight_q, inflight_d;
    logic [Psize-1:0] inflight_addr_q, inflight_addr_d;
    logic [CNT_W-1:0] count;
    logic [Isize-1:0] head_data;
    logic [Psize-1:0] head_addr;
    logic             handshake_pop;
    logic             pop;
    logic             push;
    logic             accept;
    logic             room;

    // ROM is addressed straight from the PC; its data lands one cycle later
    assign bus.rom_addr = bus.req_addr;

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = head_data;
    assign bus.instr_addr  = head_addr;

    // Occupancy after this cycle (buffered + in flight - popped) must stay below depth
    assign handshake_pop = bus.instr_valid && bus.instr_ready;
    assign room = (OCC_W'(count) + OCC_W'(inflight_q)) <
                  (OCC_W'(FETCH_DEPTH) + OCC_W'(handshake_pop));

    // A flush empties everything, so the branch target is always accepted
    assign bus.req_ready = reset && (bus.flush || room);

    assign accept = bus.req_valid && bus.req_ready;
    assign pop    = handshake_pop && !bus.flush;
    assign push   = inflight_q && !bus.flush;

    // In-flight tracking: set by an accept, otherwise the word lands (or is flushed)
    always_comb begin
        inflight_d      = 1'b0;
        inflight_addr_d = inflight_addr_q;
        if (accept) begin
            inflight_d      = 1'b1;
            inflight_addr_d = bus.req_addr;
        end
    end

    // In-flight registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            inflight_q      <= inflight_d;
            inflight_addr_q <= inflight_addr_d;
        end
    end

    fetch_fifo #(
        .Psize (Psize),
        .Isize (Isize)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (bus.flush),
        .push_data_i (bus.rom_data),
        .push_addr_i (inflight_addr_q),
        .count_o     (count),
        .head_data_o (head_data),
        .head_addr_o (head_addr)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector bench for instr_fetch with a synchronous ROM model (ROM[i] = 0x100 + i).
module tb_instr_fetch;
    import picomips_pkg::*;

    typedef struct {
        logic             rst_n;
        logic             rv;
        logic [PSIZE-1:0] ra;
        logic             fl;
        logic             ir;
        logic             e_rr;
        logic             e_iv;
        logic             chk;
        logic [PSIZE-1:0] e_ia;
        logic [ISIZE-1:0] e_in;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    vec_t             vecs [$];
    logic [ISIZE-1:0] rom [2**PSIZE];
    logic [PSIZE-1:0] sb [$];
    bit               ir_pat [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    instr_fetch_if bus ();

    instr_fetch u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous program ROM
    always_ff @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic add(input int rst_n, input int rv, input int ra, input int fl, input int ir,
                       input int e_rr, input int e_iv, input int chk, input int e_ia, input int e_in);
        vec_t v;
        v.rst_n = rst_n[0];
        v.rv    = rv[0];
        v.ra    = PSIZE'(ra);
        v.fl    = fl[0];
        v.ir    = ir[0];
        v.e_rr  = e_rr[0];
        v.e_iv  = e_iv[0];
        v.chk   = chk[0];
        v.e_ia  = PSIZE'(e_ia);
        v.e_in  = ISIZE'(e_in);
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        logic [PSIZE-1:0] exp_a;
        logic [PSIZE-1:0] next_a;
        int sent;
        int got;

        for (int i = 0; i < 2**PSIZE; i++) rom[i] = ISIZE'(32'h100 + i);

        reset           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.flush       = 1'b0;
        bus.instr_ready = 1'b0;

        //   rst rv addr   fl ir   rr iv chk ia     instr
        add(0, 0, 0,     0, 0,   0, 0, 1, 0,     0);       // in reset
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);       // released
        add(1, 1, 0,     0, 1,   1, 0, 0, 0,     0);       // stream 0..3
        add(1, 1, 1,     0, 1,   1, 0, 0, 0,     0);
        add(1, 1, 2,     0, 1,   1, 1, 1, 0,     'h100);
        add(1, 1, 3,     0, 1,   1, 1, 1, 1,     'h101);
        add(1, 0, 0,     0, 1,   1, 1, 1, 2,     'h102);
        add(1, 0, 0,     0, 1,   1, 1, 1, 3,     'h103);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 1, 5,     0, 0,   1, 0, 0, 0,     0);       // backpressure 5,6
        add(1, 1, 6,     0, 0,   1, 0, 0, 0,     0);
        add(1, 1, 7,     0, 0,   0, 1, 1, 5,     'h105);
        add(1, 1, 7,     0, 0,   0, 1, 1, 5,     'h105);
        add(1, 1, 7,     0, 0,   0, 1, 1, 5,     'h105);
        add(1, 0, 0,     0, 1,   1, 1, 1, 5,     'h105);
        add(1, 0, 0,     0, 1,   1, 1, 1, 6,     'h106);
        add(1, 0, 0,     0, 0,   1, 0, 0, 0,     0);
        add(1, 1, 7,     0, 0,   1, 0, 0, 0,     0);       // fill 7,8 then flush
        add(1, 1, 8,     0, 0,   1, 0, 0, 0,     0);
        add(1, 1, 9,     0, 0,   0, 1, 1, 7,     'h107);
        add(1, 1, 'h20,  1, 0,   1, 1, 1, 7,     'h107);   // full but ready forced
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 0, 0,     0, 1,   1, 1, 1, 'h20,  'h120);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 1, 9,     0, 0,   1, 0, 0, 0,     0);       // in-flight 9 flushed
        add(1, 1, 'h21,  1, 0,   1, 0, 0, 0,     0);
        add(1, 0, 0,     0, 0,   1, 0, 0, 0,     0);
        add(1, 0, 0,     0, 1,   1, 1, 1, 'h21,  'h121);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 1, 'h0a,  0, 0,   1, 0, 0, 0,     0);       // buffered + in-flight flushed
        add(1, 1, 'h0b,  0, 0,   1, 0, 0, 0,     0);
        add(1, 1, 'h22,  1, 1,   1, 1, 1, 'h0a,  'h10a);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 0, 0,     0, 1,   1, 1, 1, 'h22,  'h122);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 1, 'h0c,  0, 0,   1, 0, 0, 0,     0);       // full pop + accept
        add(1, 1, 'h0d,  0, 0,   1, 0, 0, 0,     0);
        add(1, 1, 'h0e,  0, 0,   0, 1, 1, 'h0c,  'h10c);
        add(1, 1, 'h0e,  0, 1,   1, 1, 1, 'h0c,  'h10c);
        add(1, 0, 0,     0, 1,   1, 1, 1, 'h0d,  'h10d);
        add(1, 0, 0,     0, 1,   1, 1, 1, 'h0e,  'h10e);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 1, 'h0f,  0, 0,   1, 0, 0, 0,     0);       // reset mid-fetch
        add(1, 1, 'h10,  0, 0,   1, 0, 0, 0,     0);
        add(0, 1, 'h11,  0, 0,   0, 0, 1, 0,     0);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);
        add(1, 0, 0,     0, 1,   1, 0, 0, 0,     0);

        foreach (vecs[i]) begin
            @(negedge clk);
            reset           = vecs[i].rst_n;
            bus.req_valid   = vecs[i].rv;
            bus.req_addr    = vecs[i].ra;
            bus.flush       = vecs[i].fl;
            bus.instr_ready = vecs[i].ir;
            #1;
            check("req_ready", i, 32'(bus.req_ready), 32'(vecs[i].e_rr));
            check("instr_valid", i, 32'(bus.instr_valid), 32'(vecs[i].e_iv));
            if (vecs[i].chk) begin
                check("instr_addr", i, 32'(bus.instr_addr), 32'(vecs[i].e_ia));
                check("instr", i, 32'(bus.instr), 32'(vecs[i].e_in));
            end
        end

        // Ten fetches drained with an irregular ready pattern, checked in order
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            @(negedge clk);
            next_a          = PSIZE'(32'h28 + sent);
            bus.flush       = 1'b0;
            bus.req_valid   = (sent < 10);
            bus.req_addr    = next_a;
            bus.instr_ready = ir_pat[cyc % 7];
            #1;
            if (bus.instr_valid && bus.instr_ready) begin
                if (sb.size() == 0) begin
                    check("wrap_spurious_pop", got, 32'(bus.instr_addr), 32'hffff_ffff);
                end else begin
                    exp_a = sb.pop_front();
                    check("wrap_addr", got, 32'(bus.instr_addr), 32'(exp_a));
                    check("wrap_data", got, 32'(bus.instr), 32'h100 + 32'(exp_a));
                end
                got++;
            end
            if (bus.req_valid && bus.req_ready) begin
                sb.push_back(next_a);
                sent++;
            end
        end
        check("wrap_popped", 0, 32'(got), 32'd10);

        // Nothing may remain once every fetched word has been consumed
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid   = 1'b0;
            bus.instr_ready = 1'b1;
            #1;
            check("wrap_drained", k, 32'(bus.instr_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter Psize, default 6, meaning program address width (64 instructions).
REQ-002 SHALL have parameter Isize, default 20, meaning instruction word width.
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 holds block in reset).
REQ-005 SHALL have port req_valid  input  1  fetch request from PC.
REQ-006 SHALL have port req_addr  input  Psize  instruction address to fetch (PCout).
REQ-007 SHALL have port req_ready  output  1  request accepted this cycle when req_valid&&req_ready.
REQ-008 SHALL have port flush  input  1  branch taken; discard all fetched and in-flight words.
REQ-009 SHALL have port rom_addr  output  Psize  address to synchronous program ROM.
REQ-010 SHALL have port rom_data  input  Isize  ROM read data, valid one cycle after rom_addr.
REQ-011 SHALL have port instr_valid  output  1  instr/instr_addr hold a fetched word.
REQ-012 SHALL have port instr  output  Isize  fetched instruction (buffer head).
REQ-013 SHALL have port instr_addr  output  Psize  address of instr.
REQ-014 SHALL have port instr_ready  input  1  decoder consumes head when instr_valid&&instr_ready.

Function
REQ-015 SHALL drive rom_addr = req_addr combinationally every cycle.
REQ-016 SHALL register accept as inflight flag plus inflight_addr; ROM data captured into buffer on next edge.
REQ-017 SHALL hold a 2-entry FIFO (count 0..2, 1-bit wptr/rptr wrapping 1->0).
REQ-018 SHALL compute pop = instr_valid&&instr_ready; req_ready = 1 iff count + inflight - pop < 2.
REQ-019 SHALL give latency: accepted in cycle N -> instr_valid in cycle N+2 with matching instr_addr.
REQ-020 SHALL sustain one instruction per cycle when instr_ready held high.
REQ-021 SHALL handle simultaneous push (inflight landing) and pop: count unchanged, order preserved.
REQ-022 SHALL assert instr_valid = (count != 0); instr/instr_addr stable while valid and not popped.
REQ-023 SHALL on flush: count, pointers, inflight cleared at edge; landing ROM word dropped; pop ignored.
REQ-024 SHALL accept a request presented in the flush cycle (branch target), req_ready forced 1 then.
REQ-025 SHALL never overflow: push when count=2 impossible by REQ-018; assertion required in RTL.
REQ-026 SHALL ignore req_addr when req_valid=0; no ROM word buffered without an accept.

Reset
REQ-027 SHALL on reset=0 asynchronously clear count, wptr, rptr, inflight, inflight_addr to 0.
REQ-028 SHALL during reset output instr_valid=0, req_ready=0, instr=0, instr_addr=0.
REQ-029 SHALL assert req_ready=1 first cycle after reset release; reset mid-fetch discards everything.

Structure
REQ-030 SHALL take Psize, Isize, FETCH_DEPTH=2 from shared package picomips_pkg.
REQ-031 SHALL implement storage as sub-module fetch_fifo (push, pop, clear, count, head data/addr).
REQ-032 SHALL keep handshake/inflight control in instr_fetch; no latches, no multi-cycle paths.

Verification
REQ-033 Reset: reset=0 mid-stream, release -> instr_valid=0, req_ready=1, count=0 next cycle.
REQ-034 Stream: addr 0,1,2,3 back-to-back, instr_ready=1, ROM[i]=i+0x100 -> instr 0x100..0x103 cycles 2..5.
REQ-035 Backpressure: instr_ready=0 after accepting addr 5,6 -> req_ready=0, head holds addr 5 until ready.
REQ-036 Flush: in-flight addr 9, buffered 7,8, flush with req_addr=0x20 -> next instr_addr=0x20, 7/8/9 never seen.
REQ-037 Full pop-push: count=2, instr_ready=1, req_valid=1 -> req_ready=1, count stays 2, order kept.
REQ-038 Wrap: 10 pushes/pops with irregular instr_ready -> scoreboard order exact, no duplicates or drops.
